muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand width (even, >= 8).
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 start_i  in  1  request; held high by EX until ready_o seen.
REQ-005 annul_i  in  1  abort current operation (flush/exception).
REQ-006 op_i  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MADDU, 101 MADD, 110 MSUBU, 111 MSUB; bit0 = signed.
REQ-007 opdata1_i  in  WIDTH  multiplicand / dividend.
REQ-008 opdata2_i  in  WIDTH  multiplier / divisor.
REQ-009 acc_i  in  2*WIDTH  {HI,LO} accumulator for MADD/MSUB.
REQ-010 result_o  out  2*WIDTH  {HI,LO}; divide: HI = remainder, LO = quotient.
REQ-011 ready_o  out  1  result valid.
REQ-012 busy_o  out  1  high whenever state != IDLE.
REQ-013 dz_o  out  1  divide-by-zero flag, valid with ready_o.

Function
REQ-014 States SHALL be IDLE, BUSY, FIX, DONE.
REQ-015 IDLE: start_i=1 and annul_i=0 SHALL capture op_i, opdata1_i, opdata2_i, acc_i, operand magnitudes (signed ops) and sign bits; later input changes SHALL be ignored until return to IDLE.
REQ-016 IDLE -> DONE directly when a divide op has opdata2_i == 0; result_o = 0, dz_o = 1.
REQ-017 Otherwise IDLE -> BUSY, iteration counter = 0.
REQ-018 BUSY SHALL perform one radix-2 step per cycle (shift-add multiply, restoring divide) on magnitudes, exactly WIDTH cycles, then -> FIX.
REQ-019 FIX (1 cycle): product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign; MADD* adds, MSUB* subtracts product from captured acc, modulo 2^(2*WIDTH); result registered.
REQ-020 DONE: ready_o = 1, result_o and dz_o held stable; -> IDLE on first cycle start_i = 0.
REQ-021 Latency: start sampled in cycle 0 -> ready_o first high in cycle WIDTH+2 (divide by zero: cycle 1).
REQ-022 ready_o SHALL be 0 in IDLE, BUSY, FIX.
REQ-023 annul_i = 1 in any state SHALL force IDLE at next edge, no ready_o, result_o = 0; annul_i has priority over start_i.
REQ-024 Signed DIV of most-negative by -1 SHALL give quotient = most-negative (wrap), remainder = 0, dz_o = 0.
REQ-025 Unsigned ops SHALL use operands unmodified; MADDU/MSUBU use unsigned product.
REQ-026 start_i held high after DONE->IDLE without deassertion SHALL NOT occur; if start_i stays high, DONE persists (no restart).
REQ-027 dz_o SHALL be 0 for all multiply ops and clear on leaving DONE.

Reset
REQ-028 rst = 1 SHALL immediately force state IDLE, counter 0, ready_o 0, busy_o 0, dz_o 0, result_o 0, independent of clk.
REQ-029 Reset mid-operation SHALL discard the operation; first start after release behaves as from power-up.

Verification (WIDTH=32)
REQ-030 MULT 0xFFFFFFFE x 0x00000003 -> ready_o in cycle 34, result_o = 0xFFFFFFFF_FFFFFFFA.
REQ-031 DIV 0xFFFFFFF9 / 0x00000002 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFD, dz_o = 0.
REQ-032 DIVU 5 / 0 -> ready_o in cycle 1, result_o = 0, dz_o = 1; DIV 0x80000000 / 0xFFFFFFFF -> HI = 0, LO = 0x80000000.
REQ-033 MSUB acc = 0x00000000_0000000A, 3 x 4 -> result_o = 0xFFFFFFFF_FFFFFFFE; MADDU acc = 0xFFFFFFFF_FFFFFFFF, 1 x 1 -> 0.
REQ-034 MULTU started, annul_i pulsed in cycle 10 -> IDLE in cycle 11, ready_o never high; next DIVU 100/7 -> HI = 2, LO = 14.
REQ-035 rst asserted asynchronously in cycle 20 of a DIV -> outputs 0 before next edge; following MULTU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE_00000001.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide
// over operand magnitudes, with a one-cycle sign fix-up and optional accumulate.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic [2:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 dz_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2:0]           op_q;
  logic                 sign1_q;
  logic                 sign2_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   p_q;

  logic                 is_div_in;
  logic [WIDTH-1:0]     mag1;
  logic [WIDTH-1:0]     mag2;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   p_next;
  logic                 neg;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   fix_res;

  assign is_div_in = (op_i[2:1] == 2'b01);
  assign mag1 = (op_i[0] && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (op_i[0] && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // p_q holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_diff = p_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    if (op_q[2:1] == 2'b01)
      p_next = div_diff[WIDTH] ? {p_q[2*WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    else
      p_next = {mul_sum, p_q[WIDTH-1:1]};
  end

  always_comb begin
    neg  = sign1_q ^ sign2_q;
    quo  = neg ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    rem  = sign1_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    prod = neg ? -p_q : p_q;
    case (op_q[2:1])
      2'b01:   fix_res = {rem, quo};
      2'b10:   fix_res = acc_q + prod;
      2'b11:   fix_res = acc_q - prod;
      default: fix_res = prod;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
      dz_o     <= 1'b0;
    end else if (annul_i) begin
      state    <= IDLE;
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
      dz_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            op_q    <= op_i;
            acc_q   <= acc_i;
            sign1_q <= op_i[0] & opdata1_i[WIDTH-1];
            sign2_q <= op_i[0] & opdata2_i[WIDTH-1];
            busy_o  <= 1'b1;
            cnt     <= '0;
            if (is_div_in && opdata2_i == '0) begin
              state    <= DONE;
              result_o <= '0;
              dz_o     <= 1'b1;
              ready_o  <= 1'b1;
            end else begin
              state <= BUSY;
              b_q   <= is_div_in ? mag2 : mag1;
              p_q   <= {{WIDTH{1'b0}}, (is_div_in ? mag1 : mag2)};
            end
          end
        end
        BUSY: begin
          p_q <= p_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1))
            state <= FIX;
        end
        FIX: begin
          result_o <= fix_res;
          ready_o  <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (!start_i) begin
            state   <= IDLE;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
            dz_o    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit at WIDTH=32; expected results come
// from a behavioural model and are queued at issue, then popped at ready_o.
module tb_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          annul_i;
  logic [2:0]    op_i;
  logic [W-1:0]  opdata1_i;
  logic [W-1:0]  opdata2_i;
  logic [2*W-1:0] acc_i;
  logic [2*W-1:0] result_o;
  logic          ready_o;
  logic          busy_o;
  logic          dz_o;

  typedef struct {
    logic [2*W-1:0] res;
    logic           dz;
    int             lat;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .acc_i(acc_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o), .dz_o(dz_o)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [2*W-1:0] acc);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [2*W-1:0]  p;
    int              qi, ri;
    if (op[2:1] == 2'b01) begin
      if (b == '0) return '0;
      if (op[0]) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        qi = $signed(a) / $signed(b);
        ri = $signed(a) % $signed(b);
        return {ri[31:0], qi[31:0]};
      end
      return {a % b, a / b};
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    p  = op[0] ? 64'(sa * sb) : 64'(ua * ub);
    case (op[2:1])
      2'b10:   return acc + p;
      2'b11:   return acc - p;
      default: return p;
    endcase
  endfunction

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [2*W-1:0] acc);
    exp_t e;
    e.res = model(op, a, b, acc);
    e.dz  = (op[2:1] == 2'b01) && (b == '0);
    e.lat = e.dz ? 1 : W + 2;
    sb_q.push_back(e);
    op_i      = op;
    opdata1_i = a;
    opdata2_i = b;
    acc_i     = acc;
    start_i   = 1'b1;
  endtask

  // Inputs are scrambled after the start edge to prove they are captured.
  task automatic checkOutput(input string tag);
    exp_t e;
    int   cycles;
    e = sb_q.pop_front();
    cycles = 0;
    while (cycles < 100) begin
      step();
      cycles++;
      if (cycles == 1) begin
        op_i      = 3'($urandom);
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        acc_i     = {$urandom, $urandom};
      end
      if (ready_o) break;
    end
    check({tag, "_latency"}, 64'(cycles), 64'(e.lat));
    check({tag, "_result"}, result_o, e.res);
    check({tag, "_dz"}, 64'(dz_o), 64'(e.dz));
    step();
    check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
    check({tag, "_hold_result"}, result_o, e.res);
    start_i = 1'b0;
    step();
    check({tag, "_idle_ready"}, 64'(ready_o), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_idle_dz"}, 64'(dz_o), 64'd0);
  endtask

  initial begin
    int ready_seen;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = '0;
    opdata1_i = '0; opdata2_i = '0; acc_i = '0;
    step(); step();
    check("reset_result", result_o, 64'd0);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_dz", 64'(dz_o), 64'd0);
    rst = 1'b0;
    step();

    applyStimulus(3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 64'h0);
    checkOutput("mult");
    applyStimulus(3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 64'h0);
    checkOutput("div_neg");
    applyStimulus(3'b010, 32'd5, 32'd0, 64'h0);
    checkOutput("divu_zero");
    applyStimulus(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0);
    checkOutput("div_wrap");
    applyStimulus(3'b111, 32'd3, 32'd4, 64'h0000_0000_0000_000A);
    checkOutput("msub");
    applyStimulus(3'b100, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("maddu");
    applyStimulus(3'b101, 32'hFFFF_FFFE, 32'd5, 64'd100);
    checkOutput("madd");
    applyStimulus(3'b110, 32'h8000_0000, 32'd2, 64'h0000_0002_0000_0000);
    checkOutput("msubu");
    applyStimulus(3'b011, 32'd7, 32'hFFFF_FFFE, 64'h0);
    checkOutput("div_rem_sign");

    // Annul a MULTU in cycle 10.
    op_i = 3'b000; opdata1_i = 32'h1234_5678; opdata2_i = 32'h9ABC_DEF0; start_i = 1'b1;
    ready_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ready_o) ready_seen++;
    end
    annul_i = 1'b1;
    step();
    if (ready_o) ready_seen++;
    check("annul_busy", 64'(busy_o), 64'd0);
    check("annul_result", result_o, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ready_o) ready_seen++;
    end
    check("annul_no_ready", 64'(ready_seen), 64'd0);
    applyStimulus(3'b010, 32'd100, 32'd7, 64'h0);
    checkOutput("divu_after_annul");

    // Asynchronous reset in cycle 20 of a DIV.
    op_i = 3'b011; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("pre_rst_busy", 64'(busy_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy_o), 64'd0);
    check("async_rst_result", result_o, 64'd0);
    check("async_rst_ready", 64'(ready_o), 64'd0);
    start_i = 1'b0;
    step();
    rst = 1'b0;
    step();
    applyStimulus(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0);
    checkOutput("multu_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
